excess3_to_bcd_serial: RTL
==========================

EXCESS3_TO_BCD_SERIAL -- requirements
Module: excess3_to_bcd_serial

Interface
REQ-001 Parameter: NUM_DIGITS, default 4, number of digits per frame (range 1..15).
REQ-002 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: x_in  input  1  serial Excess-3 data bit, LSB first, 4 bits per digit.
REQ-005 Port: x_en  input  1  bit-accept qualifier; x_in is consumed only on edges where x_en=1.
REQ-006 Port: y_out  output  1  serial BCD bit (Mealy, combinational from state and x_in).
REQ-007 Port: bcd_digit  output  4  last valid BCD digit, registered.
REQ-008 Port: digit_valid  output  1  one-cycle pulse: a valid digit was completed.
REQ-009 Port: code_err  output  1  one-cycle pulse: the completed digit was an illegal Excess-3 code.
REQ-010 Port: frame_done  output  1  one-cycle pulse: NUM_DIGITS digits were completed, counting both valid and illegal digits.

Function
REQ-011 The block SHALL implement a 7-state Mealy FSM: S0 (bit0 expected); S1B/S1N (bit1 expected, borrow/no borrow); S2B/S2N (bit2); S3B/S3N (bit3).
REQ-012 Bit0 SHALL produce y_out=~x, borrow=~x, next state S1B if borrow else S1N.
REQ-013 Bit1 SHALL produce y_out=x^1^b, borrow=~x|b, next state S2B/S2N.
REQ-014 Bit2 SHALL produce y_out=x^b, borrow=~x&b, next state S3B/S3N.
REQ-015 Bit3 SHALL produce y_out=x^b; final borrow=~x&b; next state S0.
REQ-016 Combined effect of REQ-012..015: y_out stream = (x - 4'b0011) mod 16, LSB first, zero added latency.
REQ-017 When x_en=0, y_out SHALL be 0 and FSM, shift register, and counters SHALL hold.
REQ-018 A 4-bit shift register SHALL capture accepted x_in bits, so the full input code is known at bit3.
REQ-019 On the bit3 edge, a code in the range 0011..1100 SHALL load bcd_digit=code-3 and pulse digit_valid on the following cycle.
REQ-020 A code of 0000..0010 (final borrow=1) or 1101..1111 SHALL pulse code_err and leave bcd_digit unchanged.
REQ-021 For illegal codes, y_out bits already emitted SHALL NOT be suppressed.
REQ-022 digit_valid and code_err SHALL never be asserted in the same cycle.
REQ-023 A digit counter (4 bits) SHALL increment per completed digit; on reaching NUM_DIGITS it SHALL wrap to 0 and pulse frame_done, coincident with that digit's digit_valid/code_err.
REQ-024 Bits SHALL be accepted back-to-back: bit0 of the next digit MAY be accepted on the cycle after bit3.

Reset
REQ-025 While reset=1: FSM=S0, shift register=0, digit counter=0, bcd_digit=0, and digit_valid, code_err, and frame_done all 0.
REQ-026 While reset=1, y_out SHALL be 0.
REQ-027 Reset mid-digit SHALL discard the partial digit with no pulse; the first accepted bit after reset is bit0.
REQ-028 Reset SHALL take priority over x_en.

Structure
REQ-029 A shared package SHALL hold the state encoding, DIGIT_W=4, E3_OFFSET=3, E3_MIN=4'b0011, and E3_MAX=4'b1100.
REQ-030 The legality check and code-3 subtraction SHALL be one combinational sub-module, e3_digit_check (in: code[3:0]; out: legal, bcd[3:0]).

Verification
REQ-031 Reset, then x_en=1 and x_in=0,0,0,1 (code 1000) -> y_out=1,0,1,0; bcd_digit=0101; one digit_valid pulse.
REQ-032 x_in=0,0,1,1 (1100) then 1,1,0,0 (0011) back-to-back -> bcd_digit 1001 then 0000; two digit_valid pulses; no gap cycles.
REQ-033 x_in=0,1,0,0 (0010) -> y_out=1,1,1,1; code_err pulse; bcd_digit unchanged. Repeat with x_in=1,0,1,1 (1101) -> code_err.
REQ-034 x_en=0 for 3 cycles between bit1 and bit2 of code 0111 -> y_out=0 during the gap; bcd_digit=0100; a single digit_valid pulse.
REQ-035 reset asserted after bit2, then full code 1000 -> no pulse for the aborted digit; bcd_digit=0101.
REQ-036 NUM_DIGITS=4 with 5 digits, third one illegal -> frame_done coincident with the 4th completion only; counter=1 after the 5th.

Source files
------------

// File: rtl/excess3_to_bcd_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : excess3_to_bcd_serial_pkg
// Description : Shared digit constants and FSM state encoding for the serial
//               Excess-3 to BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
package excess3_to_bcd_serial_pkg;

    localparam int                 DIGIT_W   = 4;
    localparam logic [DIGIT_W-1:0] E3_OFFSET = 4'd3;
    localparam logic [DIGIT_W-1:0] E3_MIN    = 4'b0011;
    localparam logic [DIGIT_W-1:0] E3_MAX    = 4'b1100;

    // B/N suffix: a borrow is / is not pending into the next bit position.
    typedef enum logic [2:0] {
        ST_S0  = 3'd0,
        ST_S1B = 3'd1,
        ST_S1N = 3'd2,
        ST_S2B = 3'd3,
        ST_S2N = 3'd4,
        ST_S3B = 3'd5,
        ST_S3N = 3'd6
    } e3_state_t;

endpackage
`default_nettype wire

// File: rtl/excess3_to_bcd_serial_e3_digit_check.sv
`default_nettype none
// ============================================================================
// Module      : e3_digit_check
// Description : Combinational Excess-3 legality check and code-3 subtraction.
// Revision    : 1.0 - initial release
// ============================================================================
module e3_digit_check
    import excess3_to_bcd_serial_pkg::*;
(
    input  logic [DIGIT_W-1:0] code,
    output logic               legal,
    output logic [DIGIT_W-1:0] bcd
);

    assign legal = (code >= E3_MIN) && (code <= E3_MAX);
    assign bcd   = code - E3_OFFSET;

endmodule
`default_nettype wire

// File: rtl/excess3_to_bcd_serial.sv
`default_nettype none
// ============================================================================
// Module      : excess3_to_bcd_serial
// Description : Bit-serial (LSB first) Excess-3 to BCD converter with Mealy
//               serial output, registered digit capture and frame counting.
// Revision    : 1.0 - initial release
// ============================================================================
module excess3_to_bcd_serial
    import excess3_to_bcd_serial_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               x_in,
    input  logic               x_en,
    output logic               y_out,
    output logic [DIGIT_W-1:0] bcd_digit,
    output logic               digit_valid,
    output logic               code_err,
    output logic               frame_done
);

    localparam logic [3:0] C_LAST_DIGIT = 4'(NUM_DIGITS - 1);

    e3_state_t          r_state;
    e3_state_t          w_state_nxt;
    logic               w_y;
    logic               w_bit3;
    logic [DIGIT_W-1:0] r_shift;
    logic [3:0]         r_cnt;
    logic [DIGIT_W-1:0] r_bcd;
    logic               r_valid;
    logic               r_err;
    logic               r_frame;
    logic [DIGIT_W-1:0] w_code;
    logic               w_legal;
    logic [DIGIT_W-1:0] w_bcd;
    logic               w_shift_unused;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_S0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Serial subtract-3: constant 0011 folded into the per-state equations.
    always_comb begin
        w_state_nxt = r_state;
        w_y         = 1'b0;
        w_bit3      = 1'b0;
        if (x_en) begin
            case (r_state)
                ST_S0: begin
                    w_y         = ~x_in;
                    w_state_nxt = x_in ? ST_S1N : ST_S1B;
                end
                ST_S1B: begin
                    w_y         = x_in;
                    w_state_nxt = ST_S2B;
                end
                ST_S1N: begin
                    w_y         = ~x_in;
                    w_state_nxt = x_in ? ST_S2N : ST_S2B;
                end
                ST_S2B: begin
                    w_y         = ~x_in;
                    w_state_nxt = x_in ? ST_S3N : ST_S3B;
                end
                ST_S2N: begin
                    w_y         = x_in;
                    w_state_nxt = ST_S3N;
                end
                ST_S3B: begin
                    w_y         = ~x_in;
                    w_bit3      = 1'b1;
                    w_state_nxt = ST_S0;
                end
                ST_S3N: begin
                    w_y         = x_in;
                    w_bit3      = 1'b1;
                    w_state_nxt = ST_S0;
                end
                default: begin
                    w_state_nxt = ST_S0;
                end
            endcase
        end
    end

    assign y_out = w_y & ~reset;

    // Bits arrive LSB first, so the newest bit is the MSB of the code.
    assign w_code         = {x_in, r_shift[DIGIT_W-1:1]};
    assign w_shift_unused = r_shift[0];

    e3_digit_check u_check (
        .code  (w_code),
        .legal (w_legal),
        .bcd   (w_bcd)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_frame <= 1'b0;
            if (x_en) begin
                r_shift <= w_code;
                if (w_bit3) begin
                    if (w_legal) begin
                        r_valid <= 1'b1;
                        r_bcd   <= w_bcd;
                    end else begin
                        r_err   <= 1'b1;
                    end
                    if (r_cnt == C_LAST_DIGIT) begin
                        r_cnt   <= '0;
                        r_frame <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
            end
        end
    end

    assign bcd_digit   = r_bcd;
    assign digit_valid = r_valid;
    assign code_err    = r_err;
    assign frame_done  = r_frame;

endmodule
`default_nettype wire
